muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in EX.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv_unit.sv | 105 ++++++++++
 tb/tb_muldiv_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state types and operand signedness helpers for the M-extension unit
package muldiv_pkg;
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} muldiv_state_e;
   function automatic logic is_div(input muldiv_op_e op);
      return op[2];
   endfunction
   function automatic logic is_signed_a(input muldiv_op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction
   function automatic logic is_signed_b(input muldiv_op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: STEP_BITS-deep unsigned shift-add (mul) or restoring shift-subtract (div) slice
module muldiv_step #(
   parameter int XLEN      = 32,
   parameter int STEP_BITS = 1
) (
   input  logic                div_i,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     opnd_i,
   output logic [2*XLEN-1:0]   acc_o
);
   localparam int W = 2 * XLEN;
   logic [XLEN:0] rem, diff, sum;
   // div: acc = {remainder, dividend->quotient}; mul: acc = {partial hi, multiplier->product lo}
   always_comb begin
      acc_o = acc_i;
      rem   = '0;
      diff  = '0;
      sum   = '0;
      for (int i = 0; i < STEP_BITS; i++) begin
         rem   = {acc_o[W-1:XLEN], acc_o[XLEN-1]};
         diff  = rem - {1'b0, opnd_i};
         sum   = {1'b0, acc_o[W-1:XLEN]} + (acc_o[0] ? {1'b0, opnd_i} : '0);
         acc_o = div_i ? (diff[XLEN] ? {rem[XLEN-1:0], acc_o[XLEN-2:0], 1'b0}
                                     : {diff[XLEN-1:0], acc_o[XLEN-2:0], 1'b1})
                       : {sum, acc_o[XLEN-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with pipeline stall, flush and
// RISC-V corner-case results.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int XLEN          = 32,
   parameter int STEP_BITS     = 1,
   parameter int EARLY_SPECIAL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);
   localparam int N  = XLEN / STEP_BITS;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e     state_q;
   muldiv_op_e        op, op_q;
   logic [CW-1:0]     cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_d, full;
   logic [XLEN-1:0]   opnd_q, spec_res_q, result_q, result_d;
   logic [XLEN-1:0]   abs_a, abs_b, spec_res, dsel;
   logic              neg_q, spec_q, sa, sb, b_zero, ovf, spec, neg;

   assign op       = muldiv_op_e'(funct3_i);
   assign sa       = is_signed_a(op) & op_a_i[XLEN-1];
   assign sb       = is_signed_b(op) & op_b_i[XLEN-1];
   assign abs_a    = sa ? -op_a_i : op_a_i;
   assign abs_b    = sb ? -op_b_i : op_b_i;
   assign b_zero   = op_b_i == '0;
   assign ovf      = ~funct3_i[0] & (op_a_i == MIN_INT) & (&op_b_i);
   assign spec     = is_div(op) & (b_zero | ovf);
   assign spec_res = b_zero ? (op[1] ? op_a_i : '1) : (op[1] ? '0 : MIN_INT);
   assign neg      = (is_div(op) & op[1]) ? sa : sa ^ sb;

   muldiv_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
      .div_i  (is_div(op_q)),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (acc_d)
   );

   // multiply negates the full 2*XLEN product before picking a half; divide negates the chosen half
   assign full     = neg_q ? -acc_q : acc_q;
   assign dsel     = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
   assign result_d = spec_q ? spec_res_q
                   : is_div(op_q) ? (neg_q ? -dsel : dsel)
                   : (op_q == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_MUL;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               op_q       <= op;
               acc_q      <= {{XLEN{1'b0}}, abs_a};
               opnd_q     <= abs_b;
               neg_q      <= neg;
               spec_q     <= spec;
               spec_res_q <= spec_res;
               cnt_q      <= CW'(N);
               if (EARLY_SPECIAL != 0 && spec) begin
                  result_q <= spec_res;
                  state_q  <= S_DONE;
               end else begin
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_FIX;
            end
            S_FIX: begin
               result_q <= result_d;
               state_q  <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_o  = (start_i & (state_q == S_IDLE)) | (state_q == S_BUSY) | (state_q == S_FIX);
   assign done_o   = state_q == S_DONE;
   assign busy_o   = state_q != S_IDLE;
   assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at XLEN=32/STEP_BITS=1 and XLEN=64/STEP_BITS=4
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  f3;
   logic [31:0] a, b, res;
   logic        stall, done, busy;
   logic        reset64, start64, flush64;
   logic [2:0]  f3_64;
   logic [63:0] a64, b64, res64;
   logic        stall64, done64, busy64;
   int          nvec = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .STEP_BITS(1), .EARLY_SPECIAL(1)) dut32 (
      .clk(clk), .reset(reset), .start_i(start), .funct3_i(f3), .op_a_i(a), .op_b_i(b),
      .flush_i(flush), .stall_o(stall), .done_o(done), .result_o(res), .busy_o(busy)
   );

   muldiv_unit #(.XLEN(64), .STEP_BITS(4), .EARLY_SPECIAL(1)) dut64 (
      .clk(clk), .reset(reset64), .start_i(start64), .funct3_i(f3_64), .op_a_i(a64), .op_b_i(b64),
      .flush_i(flush64), .stall_o(stall64), .done_o(done64), .result_o(res64), .busy_o(busy64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat);
      int cyc, st;
      @(negedge clk);
      f3 = f; a = x; b = y; start = 1'b1;
      #1;
      st  = stall ? 1 : 0;
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (stall) st++;
      end
      chk({tag, "_res"}, 64'(res), 64'(exp));
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_stall"}, 64'(st), 64'(lat));
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic op64(input string tag, input logic [2:0] f, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat);
      int cyc;
      @(negedge clk);
      f3_64 = f; a64 = x; b64 = y; start64 = 1'b1;
      cyc = 0;
      while (!done64 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_res"}, res64, exp);
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      start64 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int seen;
      reset = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'd0; a = '0; b = '0;
      reset64 = 1'b1; start64 = 1'b0; flush64 = 1'b0; f3_64 = 3'd0; a64 = '0; b64 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 64'(stall), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_res", 64'(res), 64'(0));
      @(negedge clk);
      reset = 1'b0; reset64 = 1'b0;

      op32("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
      op32("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
      op32("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      op32("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      op32("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      op32("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      op32("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
      op32("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      op32("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
      op32("div_m5_0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
      op32("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
      op32("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      op32("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      op32("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      op32("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
      op32("mulh_m3_5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 34);
      op32("mul_m3_5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34);

      // abort during BUSY cycle 10; old result must survive
      @(negedge clk);
      f3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("flush_busy_before", 64'(busy), 64'(1));
      flush = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("flush_idle", 64'(busy), 64'(0));
      chk("flush_done", 64'(done), 64'(0));
      chk("flush_res_kept", 64'(res), 64'hFFFF_FFF1);
      flush = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("flush_no_done", 64'(seen), 64'(0));
      op32("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

      // flush beats a simultaneous start
      @(negedge clk);
      f3 = 3'b101; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_vs_start", 64'(busy), 64'(0));
      start = 1'b0; flush = 1'b0;

      op64("d64_div", 3'b100, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 18);
      op64("d64_rem", 3'b110, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 18);
      op64("d64_mulh_min", 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 18);
      op64("d64_divu_0", 3'b101, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      op64("d64_mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 18);

      // reset in the middle of an op discards it
      @(negedge clk);
      f3_64 = 3'b101; a64 = 64'd77; b64 = 64'd5; start64 = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset64 = 1'b1; start64 = 1'b0;
      @(posedge clk); #1;
      chk("d64_rst_res", res64, 64'd0);
      chk("d64_rst_busy", 64'(busy64), 64'(0));
      chk("d64_rst_done", 64'(done64), 64'(0));
      chk("d64_rst_stall", 64'(stall64), 64'(0));
      @(negedge clk);
      reset64 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
